sm_board_input: RTL
===================

// Module: sm_board_input
// PURPOSE
//  Input-side conditioner for board tops: synchronizes and debounces raw active-low push-buttons/switches.
//  Emits clean levels plus single-cycle press/release pulses.
//  Drives the core's debug register-select (regAddr) and a single-step clock-enable pulse.
//  Sits between board pins and sm_top, as the input counterpart of the LED register display.
// PARAMETERS
//  N_BTN      2      number of raw button inputs (>=2; btn 0 = address step, btn 1 = single step)
//  DB_CYCLES  50000  consecutive stable cycles required to accept a new level (>=2)
//  CNT_W      16     debounce counter width; must satisfy 2**CNT_W > DB_CYCLES
//  ADDR_W     5      width of regAddr (register file index)
//  RPT_CYCLES 500000 auto-repeat period in cycles (used only with SM_INPUT_AUTOREPEAT_EN)
// PORTS
//  clk        in   1       system clock
//  rst        in   1       synchronous reset, active-high
//  btn_raw    in   N_BTN   raw pin levels, active-low, asynchronous to clk
//  btn_level  out  N_BTN   debounced level, active-high (1 = pressed)
//  btn_press  out  N_BTN   1-cycle pulse on accepted press
//  btn_rel    out  N_BTN   1-cycle pulse on accepted release
//  regAddr    out  ADDR_W  debug register select for sm_top
//  stepPulse  out  1       1-cycle clock-enable pulse for single-step
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): btn_level=0, btn_press=0, btn_rel=0, regAddr=0, stepPulse=0.
//    Sync stages load 1 (released), so no spurious press after reset. Debounce counters = 0.
//    Reset mid-debounce discards the pending change.
//  - Sync: 2-FF synchronizer per bit on ~btn_raw; its output is s.
//  - Debounce, per bit, 2-state FSM:
//    STABLE: s==btn_level -> cnt=0.
//      s!=btn_level -> enter PENDING, cnt=1.
//    PENDING: s==btn_level -> back to STABLE, cnt=0 (glitch rejected).
//      s!=btn_level and cnt==DB_CYCLES-1 -> btn_level<=s, STABLE, cnt=0.
//      Otherwise cnt++.
//    Accept latency: DB_CYCLES + 2 sync cycles after the pin settles. Registered outputs add 1 further cycle.
//  - Pulses: btn_press is asserted in the cycle after btn_level rises 0->1; btn_rel after it falls 1->0.
//    Each lasts exactly 1 cycle. Pulses of different bits are independent and may coincide.
//  - regAddr: +1 mod 2**ADDR_W on each btn_press[0]. All-ones wraps to 0.
//  - stepPulse: equals btn_press[1], registered (1 cycle after btn_press[1]). Never wider than 1 cycle.
//  - Simultaneous press on bits 0 and 1: both actions occur in the same cycle.
// CONFIGURATION
//  SM_INPUT_AUTOREPEAT_EN defined: while btn_level[0]=1, a repeat counter runs.
//    First repeat fires RPT_CYCLES after the press, then every RPT_CYCLES.
//    Each repeat increments regAddr exactly like a press. btn_press[0] itself is NOT re-pulsed.
//    Counter clears on release or rst.
//  Undefined: no repeat counter is instantiated; regAddr changes only on btn_press[0].
// STRUCTURE
//  - sm_board_pkg.vh (shared include): SM_BTN_ADDR=0, SM_BTN_STEP=1, default DB_CYCLES/RPT_CYCLES,
//    debounce state encodings DB_STABLE=1'b0, DB_PENDING=1'b1.
//  - Sub-module sm_debounce: one bit of sync + FSM + edge pulses, with params DB_CYCLES and CNT_W.
//    Instantiated N_BTN times via generate.
//  - Top contains the regAddr counter, stepPulse register and the optional repeat counter.
// TESTING (bench uses DB_CYCLES=4, RPT_CYCLES=16, ADDR_W=5)
//  - Reset with btn_raw=all-1 held 20 cycles -> every output 0, no pulses during or after reset.
//  - btn_raw[0] low for 3 cycles, then high -> glitch rejected: btn_level[0], btn_press[0] and regAddr stay 0.
//  - btn_raw[0] held low 10 cycles -> btn_level[0]=1 within 2+4 cycles, one btn_press[0], regAddr=1.
//    Release -> one btn_rel[0], regAddr still 1.
//  - 32 clean presses of btn 0 from regAddr=0 -> regAddr back to 0 (wrap at 31->0).
//  - btn_raw[1] held low 50 cycles -> exactly one stepPulse. Holding both buttons -> regAddr+1 and stepPulse in the same cycle.
//  - With SM_INPUT_AUTOREPEAT_EN, btn 0 held 60 cycles -> regAddr=4 (press at ~t6, repeats at +16/+32/+48).
//    Without the macro -> regAddr=1.
//    Assert rst mid-hold -> regAddr=0 and no further repeats.

Source files
------------

// File: rtl/sm_board_pkg.sv
// Shared constants for the board-input conditioner: button roles, default timing and
// debounce state encoding.
package sm_board_pkg;

    localparam int SM_BTN_ADDR       = 0;
    localparam int SM_BTN_STEP       = 1;
    localparam int SM_DB_CYCLES_DEF  = 50000;
    localparam int SM_RPT_CYCLES_DEF = 500000;

    typedef enum logic {
        DB_STABLE  = 1'b0,
        DB_PENDING = 1'b1
    } db_state_e;

endpackage

// File: rtl/sm_debounce.sv
// One button bit: 2-FF synchronizer on the active-low pin, debounce FSM, and
// registered single-cycle press/release pulses that trail the level change by one cycle.
module sm_debounce
    import sm_board_pkg::*;
#(
    parameter int DB_CYCLES = SM_DB_CYCLES_DEF,
    parameter int CNT_W     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic level,
    output logic press,
    output logic rel
);

    logic             sync1_q;
    logic             sync2_q;
    logic             s;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             prev_q;
    logic             press_q, press_d;
    logic             rel_q, rel_d;

    // Synchronizer holds the raw pin value, so loading 1 means "released".
    assign s = ~sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        case (state_q)
            DB_STABLE: begin
                if (s != level_q) begin
                    state_d = DB_PENDING;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            DB_PENDING: begin
                if (s == level_q) begin
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                    level_d = s;
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = DB_STABLE;
                cnt_d   = '0;
            end
        endcase
        press_d = level_q & ~prev_q;
        rel_d   = ~level_q & prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= DB_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync1_q <= raw_n;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= level_q;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign level = level_q;
    assign press = press_q;
    assign rel   = rel_q;

endmodule

// File: rtl/sm_board_input.sv
// Board input conditioner: per-button debounce, debug register-select counter and
// single-step pulse. Define SM_INPUT_AUTOREPEAT_EN to auto-repeat the address button.
module sm_board_input
    import sm_board_pkg::*;
#(
    parameter int N_BTN      = 2,
    parameter int DB_CYCLES  = SM_DB_CYCLES_DEF,
    parameter int CNT_W      = 16,
    parameter int ADDR_W     = 5,
    parameter int RPT_CYCLES = SM_RPT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BTN-1:0]  btn_raw,
    output logic [N_BTN-1:0]  btn_level,
    output logic [N_BTN-1:0]  btn_press,
    output logic [N_BTN-1:0]  btn_rel,
    output logic [ADDR_W-1:0] regAddr,
    output logic              stepPulse
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              step_q, step_d;
    logic              rpt_fire;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        sm_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw_n (btn_raw[i]),
            .level (btn_level[i]),
            .press (btn_press[i]),
            .rel   (btn_rel[i])
        );
    end

`ifdef SM_INPUT_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(RPT_CYCLES + 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;

    // Counts held cycles; each full period fires one extra address step.
    always_comb begin
        rpt_cnt_d = '0;
        rpt_fire  = 1'b0;
        if (btn_level[SM_BTN_ADDR]) begin
            if (rpt_cnt_q == RPT_W'(RPT_CYCLES - 1)) begin
                rpt_fire = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_cnt_q <= '0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`else
    localparam int unused_rpt_cycles = RPT_CYCLES;
    assign rpt_fire = 1'b0;
`endif

    always_comb begin
        addr_d = addr_q;
        if (btn_press[SM_BTN_ADDR] || rpt_fire) begin
            addr_d = addr_q + ADDR_W'(1);
        end
        step_d = btn_press[SM_BTN_STEP];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            step_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            step_q <= step_d;
        end
    end

    assign regAddr   = addr_q;
    assign stepPulse = step_q;

endmodule
